// File: rtl/uoram_pkg.sv
// Shared types for the flat ORAM frontend responder: command and error encodings,
// FSM state encoding, and chunk-geometry helpers.
package uoram_pkg;

   typedef enum logic [1:0] {
      BECMD_Update  = 2'd0,
      BECMD_Append  = 2'd1,
      BECMD_Read    = 2'd2,
      BECMD_ReadRmv = 2'd3
   } becmd_t;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'd0,
      ERR_APPEND = 2'd1,
      ERR_READ   = 2'd2,
      ERR_RANGE  = 2'd3
   } err_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WRDATA = 3'd1,
      ST_WAIT   = 3'd2,
      ST_RDDATA = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   function automatic int chunks_f(input int block_bits, input int beat_bits);
      return block_bits / beat_bits;
   endfunction

   function automatic int ci_width_f(input int chunks);
      return (chunks > 1) ? $clog2(chunks) : 1;
   endfunction

endpackage

// File: rtl/uoram_chunk_store.sv
// Beat-wide storage array with asynchronous read and a per-block valid vector.
// Only the valid vector is reset; stored data survives reset.
module uoram_chunk_store #(
   parameter int Width  = 64,
   parameter int Blocks = 8192,
   parameter int BW     = 13,
   parameter int AW     = 16
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [Width-1:0] wdata,
   input  logic [AW-1:0]   raddr,
   output logic [Width-1:0] rdata,
   input  logic            vset,
   input  logic            vclr,
   input  logic [BW-1:0]   vwaddr,
   input  logic [BW-1:0]   vraddr,
   output logic            vbit
);

   logic [Width-1:0]  mem [2**AW];
   logic [Blocks-1:0] valid;

   always_ff @(posedge Clock) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge Clock) begin
      if (!Reset)    valid <= '0;
      else if (vset) valid[vwaddr] <= 1'b1;
      else if (vclr) valid[vwaddr] <= 1'b0;
   end

   assign rdata = mem[raddr];
   assign vbit  = valid[vraddr];

endmodule

// File: rtl/uoram_flat_responder.sv
// Flat-memory target for the ORAM frontend command/data protocol.
// Define UORAM_REMOVE_SCRUB_EN to zero each chunk as its ReadRmv beat is handed out.
module uoram_flat_responder
   import uoram_pkg::*;
#(
   parameter int ORAMB         = 512,
   parameter int ORAMU         = 32,
   parameter int FEDWidth      = 64,
   parameter int NumValidBlock = 8192,
   parameter int AccessLatency = 16
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic [1:0]          Cmd,
   input  logic [ORAMU-1:0]    PAddr,
   input  logic                CmdValid,
   output logic                CmdReady,
   input  logic [FEDWidth-1:0] DataIn,
   input  logic                DataInValid,
   output logic                DataInReady,
   output logic [FEDWidth-1:0] DataOut,
   output logic                DataOutValid,
   input  logic                DataOutReady,
   output logic                ErrFlag,
   output logic [1:0]          ErrCode,
   output logic [31:0]         AccessCount
);
   // state  | meaning
   // IDLE   | CmdReady high, waiting for a command
   // WRDATA | accepting Chunks write beats, MSB chunk first
   // WAIT   | AccessLatency idle cycles
   // RDDATA | presenting Chunks read beats, MSB chunk first
   // DONE   | one cycle: ReadRmv drops the valid bit, AccessCount bumps

   localparam int Chunks  = chunks_f(ORAMB, FEDWidth);
   localparam int CIWidth = ci_width_f(Chunks);
   localparam int BAWidth = $clog2(NumValidBlock);
   localparam int AW      = BAWidth + CIWidth;
   localparam logic [15:0]        LatLoad = 16'((AccessLatency > 0) ? AccessLatency - 1 : 0);
   localparam logic [CIWidth-1:0] LastIdx = CIWidth'(Chunks - 1);

   state_t               state;
   becmd_t               cmd_q;
   becmd_t               cmd_in;
   logic [BAWidth-1:0]   addr_q;
   logic                 oor_q;
   logic                 zero_q;
   logic [CIWidth-1:0]   idx_q;
   logic [15:0]          lat_cnt;

   logic [BAWidth-1:0]   paddr_blk;
   logic                 paddr_oor;
   logic [BAWidth-1:0]   blk_sel;
   logic [CIWidth-1:0]   rd_idx;
   logic [AW-1:0]        raddr;
   logic [FEDWidth-1:0]  rdata;
   logic                 vbit;
   logic                 we;
   logic [AW-1:0]        waddr;
   logic [FEDWidth-1:0]  wdata;
   logic                 vset;
   logic                 vclr;
   logic                 in_fire;
   logic                 out_fire;
   err_t                 err_new;

   assign cmd_in    = becmd_t'(Cmd);
   assign paddr_blk = PAddr[BAWidth-1:0];
   assign paddr_oor = PAddr >= ORAMU'(NumValidBlock);
   assign in_fire   = (state == ST_WRDATA) && DataInValid && DataInReady;
   assign out_fire  = (state == ST_RDDATA) && DataOutValid && DataOutReady;

   // Chunk (Chunks-1-idx) of a block is the bitwise inverse of idx for power-of-two Chunks.
   assign blk_sel = (state == ST_IDLE) ? paddr_blk : addr_q;
   assign rd_idx  = (state == ST_RDDATA) ? idx_q + CIWidth'(1) : '0;
   assign raddr   = {blk_sel, ~rd_idx};

   assign vset = Reset && in_fire && (idx_q == LastIdx) && !oor_q;
   assign vclr = Reset && (state == ST_DONE) && (cmd_q == BECMD_ReadRmv) && !oor_q;

   always_comb begin
      we    = 1'b0;
      waddr = {addr_q, ~idx_q};
      wdata = DataIn;
      if (Reset && in_fire && !oor_q) we = 1'b1;
`ifdef UORAM_REMOVE_SCRUB_EN
      if (Reset && out_fire && (cmd_q == BECMD_ReadRmv) && !oor_q) begin
         we    = 1'b1;
         wdata = '0;
      end
`endif
   end

   always_comb begin
      err_new = ERR_NONE;
      if (paddr_oor)
         err_new = ERR_RANGE;
      else if ((cmd_in == BECMD_Append) && vbit)
         err_new = ERR_APPEND;
      else if (((cmd_in == BECMD_Read) || (cmd_in == BECMD_ReadRmv)) && !vbit)
         err_new = ERR_READ;
   end

   uoram_chunk_store #(
      .Width  (FEDWidth),
      .Blocks (NumValidBlock),
      .BW     (BAWidth),
      .AW     (AW)
   ) u_store (
      .Clock  (Clock),
      .Reset  (Reset),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .raddr  (raddr),
      .rdata  (rdata),
      .vset   (vset),
      .vclr   (vclr),
      .vwaddr (addr_q),
      .vraddr (blk_sel),
      .vbit   (vbit)
   );

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state        <= ST_IDLE;
         cmd_q        <= BECMD_Update;
         addr_q       <= '0;
         oor_q        <= 1'b0;
         zero_q       <= 1'b0;
         idx_q        <= '0;
         lat_cnt      <= '0;
         CmdReady     <= 1'b0;
         DataInReady  <= 1'b0;
         DataOutValid <= 1'b0;
         DataOut      <= '0;
         ErrFlag      <= 1'b0;
         ErrCode      <= '0;
         AccessCount  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               CmdReady <= 1'b1;
               if (CmdValid && CmdReady) begin
                  CmdReady <= 1'b0;
                  cmd_q    <= cmd_in;
                  addr_q   <= paddr_blk;
                  oor_q    <= paddr_oor;
                  zero_q   <= paddr_oor || !vbit;
                  idx_q    <= '0;
                  lat_cnt  <= LatLoad;
                  if ((err_new != ERR_NONE) && !ErrFlag) begin
                     ErrFlag <= 1'b1;
                     ErrCode <= err_new;
                  end
                  if (!cmd_in[1]) begin
                     state       <= ST_WRDATA;
                     DataInReady <= 1'b1;
                  end else if (AccessLatency == 0) begin
                     state        <= ST_RDDATA;
                     DataOutValid <= 1'b1;
                     DataOut      <= (paddr_oor || !vbit) ? '0 : rdata;
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WRDATA: begin
               if (in_fire) begin
                  idx_q <= idx_q + CIWidth'(1);
                  if (idx_q == LastIdx) begin
                     DataInReady <= 1'b0;
                     state       <= (AccessLatency == 0) ? ST_DONE : ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (lat_cnt == '0) begin
                  if (cmd_q[1]) begin
                     state        <= ST_RDDATA;
                     DataOutValid <= 1'b1;
                     DataOut      <= zero_q ? '0 : rdata;
                  end else begin
                     state <= ST_DONE;
                  end
               end else begin
                  lat_cnt <= lat_cnt - 16'd1;
               end
            end
            ST_RDDATA: begin
               if (out_fire) begin
                  if (idx_q == LastIdx) begin
                     DataOutValid <= 1'b0;
                     DataOut      <= '0;
                     state        <= ST_DONE;
                  end else begin
                     idx_q   <= idx_q + CIWidth'(1);
                     DataOut <= zero_q ? '0 : rdata;
                  end
               end
            end
            ST_DONE: begin
               AccessCount <= AccessCount + 32'd1;
               CmdReady    <= 1'b1;
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
